// File: rtl/red_pitaya_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : red_pitaya_dac_pkg
//  Description : Shared types and constants for the Red Pitaya DAC burst
//                player: FSM state encoding, DAC code width, midscale code
//                and the saturation bounds of the 14-bit signed range.
//  Revision    : 1.0 - initial release
// ============================================================================
package red_pitaya_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam int                 DAC_WIDTH    = 14;
    localparam logic [13:0]        DAC_MIDSCALE = 14'h1FFF;
    localparam logic signed [15:0] SAT_MAX      = 16'sd8191;
    localparam logic signed [15:0] SAT_MIN      = -16'sd8192;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_dac_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : red_pitaya_dac_fmt
//  Description : Combinational saturate-and-convert for one DAC lane.
//                16-bit two's complement in, 14-bit offset-inverted DAC
//                code out (0 -> 1FFF, +max -> 0000, -max -> 3FFF).
//  Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_dac_fmt
    import red_pitaya_dac_pkg::*;
(
    input  logic [15:0]          i_data,
    output logic [DAC_WIDTH-1:0] o_code
);

    logic signed [15:0]    w_sample;
    logic [DAC_WIDTH-1:0]  w_sat;

    assign w_sample = i_data;

    // Clamp to the 14-bit signed range, then flip the magnitude bits so that
    // the DAC sees an inverted offset-binary code.
    always_comb begin
        w_sat = w_sample[DAC_WIDTH-1:0];
        if (w_sample > SAT_MAX) begin
            w_sat = SAT_MAX[DAC_WIDTH-1:0];
        end else if (w_sample < SAT_MIN) begin
            w_sat = SAT_MIN[DAC_WIDTH-1:0];
        end
        o_code = {w_sat[DAC_WIDTH-1], ~w_sat[DAC_WIDTH-2:0]};
    end

endmodule
`default_nettype wire

// File: rtl/axis_red_pitaya_dac_burst.sv
`default_nettype none
// ============================================================================
//  Module      : axis_red_pitaya_dac_burst
//  Description : Triggered AXI4-Stream burst player for the Red Pitaya DAC.
//                Arm, then a trigger rising edge plays burst_len samples
//                (0 = continuous until stop), converting each lane to a
//                14-bit DAC code. Midscale is driven whenever not playing.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_red_pitaya_dac_burst
    import red_pitaya_dac_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 trg_in,
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic [13:0]          dac_dat_a,
    output logic [13:0]          dac_dat_b,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          underrun_cnt
);

    state_t                state_q, state_d;
    logic                  trg_d_q, trg_d_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [13:0]           dac_a_q, dac_a_d;
    logic [13:0]           dac_b_q, dac_b_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           urun_q, urun_d;

    logic [13:0]           w_code [0:1];
    logic                  w_trg_edge;
    logic                  w_hs;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    // One formatter per lane: lane 0 is channel A (low half), lane 1 is B.
    for (genvar i = 0; i < 2; i++) begin : g_lane
        red_pitaya_dac_fmt u_fmt (
            .i_data (s_axis_tdata[16*i +: 16]),
            .o_code (w_code[i])
        );
    end

    // Ready depends only on the state register, never on any input.
    assign s_axis_tready = (state_q == PLAY);
    assign w_hs          = s_axis_tvalid & s_axis_tready;
    assign w_trg_edge    = trg_in & ~trg_d_q;
    assign w_cnt_inc     = cnt_q + 1'b1;

    assign dac_dat_a     = dac_a_q;
    assign dac_dat_b     = dac_b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign underrun_cnt  = urun_q;

    // Next-state and output logic; stop beats completion beats trigger/arm.
    always_comb begin
        state_d = state_q;
        trg_d_d = trg_in;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dac_a_d = DAC_MIDSCALE;
        dac_b_d = DAC_MIDSCALE;
        done_d  = 1'b0;
        urun_d  = urun_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    urun_d  = 16'h0000;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (w_trg_edge) begin
                    state_d = PLAY;
                    len_d   = burst_len;
                    cnt_d   = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    // A sample accepted alongside stop is dropped.
                    state_d = IDLE;
                end else if (w_hs) begin
                    dac_a_d = w_code[0];
                    dac_b_d = w_code[1];
                    cnt_d   = w_cnt_inc;
                    if ((len_q != '0) && (w_cnt_inc == len_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dac_a_d = dac_a_q;
                    dac_b_d = dac_b_q;
                    if (urun_q != 16'hFFFF) begin
                        urun_d = urun_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; trg_d resets high so a level already
    // present at reset release is not mistaken for an edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            trg_d_q <= 1'b1;
            len_q   <= '0;
            cnt_q   <= '0;
            dac_a_q <= DAC_MIDSCALE;
            dac_b_q <= DAC_MIDSCALE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            urun_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            trg_d_q <= trg_d_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dac_a_q <= dac_a_d;
            dac_b_q <= dac_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_red_pitaya_dac_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_red_pitaya_dac_burst
//  Description : Scoreboard bench for the DAC burst player. Stimulus pushes
//                hand-computed DAC codes per accepted sample; a monitor pops
//                them one cycle after each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_red_pitaya_dac_burst;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic        d;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        arm;
    logic        stop;
    logic        trg_in;
    logic [31:0] burst_len;
    logic [13:0] dac_dat_a;
    logic [13:0] dac_dat_b;
    logic        busy;
    logic        done;
    logic [15:0] underrun_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic pend = 1'b0;

    axis_red_pitaya_dac_burst #(.CNT_WIDTH(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .arm           (arm),
        .stop          (stop),
        .trg_in        (trg_in),
        .burst_len     (burst_len),
        .dac_dat_a     (dac_dat_a),
        .dac_dat_b     (dac_dat_b),
        .busy          (busy),
        .done          (done),
        .underrun_cnt  (underrun_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at one falling edge is checked at the next.
    always @(negedge aclk) begin
        if (areset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_dac_a", {18'd0, dac_dat_a}, {18'd0, e.a});
                    chk("sb_dac_b", {18'd0, dac_dat_b}, {18'd0, e.b});
                    chk("sb_done", {31'd0, done}, {31'd0, e.d});
                end
            end else begin
                chk("no_spurious_done", {31'd0, done}, 32'd0);
            end
            pend = s_axis_tvalid & s_axis_tready;
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [13:0] ea, input logic [13:0] eb, input logic ed);
        exp_t e;
        e.a = ea;
        e.b = eb;
        e.d = ed;
        exp_q.push_back(e);
        s_axis_tdata  = {b, a};
        s_axis_tvalid = 1'b1;
        cyc();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic arm_and_trigger(input logic [31:0] len);
        burst_len = len;
        trg_in    = 1'b0;
        arm       = 1'b1;
        cyc();
        arm       = 1'b0;
        trg_in    = 1'b1;
        cyc();
        chk("tready_after_trigger", {31'd0, s_axis_tready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        arm           = 1'b0;
        stop          = 1'b0;
        trg_in        = 1'b0;
        burst_len     = 32'd0;
        cyc();
        cyc();
        areset = 1'b0;
        cyc();

        // Reset state
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_dac_a", {18'd0, dac_dat_a}, 32'h1FFF);
        chk("rst_dac_b", {18'd0, dac_dat_b}, 32'h1FFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Basic burst of 4
        arm_and_trigger(32'd4);
        chk("play_busy", {31'd0, busy}, 32'd1);
        send(16'h0000, 16'h0000, 14'h1FFF, 14'h1FFF, 1'b0);
        send(16'h0001, 16'h1FFF, 14'h1FFE, 14'h0000, 1'b0);
        send(16'hFFFF, 16'hE000, 14'h2000, 14'h3FFF, 1'b0);
        send(16'h0064, 16'h2000, 14'h1F9B, 14'h0000, 1'b1);
        chk("done_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_last_a", {18'd0, dac_dat_a}, 32'h1F9B);
        cyc();
        chk("after_done_mid", {18'd0, dac_dat_a}, 32'h1FFF);
        chk("after_done_busy", {31'd0, busy}, 32'd0);
        chk("burst_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Saturation
        arm_and_trigger(32'd1);
        send(16'h7FFF, 16'h8000, 14'h0000, 14'h3FFF, 1'b1);
        cyc();

        // Underrun: 5 idle cycles inside a 3-sample burst
        arm_and_trigger(32'd3);
        send(16'h0005, 16'hFFFE, 14'h1FFA, 14'h2001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("underrun_hold_a", {18'd0, dac_dat_a}, 32'h1FFA);
        end
        chk("underrun_cnt5", {16'd0, underrun_cnt}, 32'd5);
        chk("underrun_tready", {31'd0, s_axis_tready}, 32'd1);
        send(16'hDFFF, 16'h1FFF, 14'h3FFF, 14'h0000, 1'b0);
        send(16'h0002, 16'hFFFF, 14'h1FFD, 14'h2000, 1'b1);
        chk("underrun_kept", {16'd0, underrun_cnt}, 32'd5);
        cyc();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("arm_clears_underrun", {16'd0, underrun_cnt}, 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_from_armed_busy", {31'd0, busy}, 32'd0);

        // Continuous mode, then stop with a sample on the bus
        arm_and_trigger(32'd0);
        send(16'h000A, 16'h0000, 14'h1FF5, 14'h1FFF, 1'b0);
        send(16'h000A, 16'h0000, 14'h1FF5, 14'h1FFF, 1'b0);
        send(16'h000A, 16'h0000, 14'h1FF5, 14'h1FFF, 1'b0);
        begin
            exp_t e;
            e.a = 14'h1FFF;
            e.b = 14'h1FFF;
            e.d = 1'b0;
            exp_q.push_back(e);
        end
        s_axis_tdata  = {16'h0000, 16'h007B};
        s_axis_tvalid = 1'b1;
        stop          = 1'b1;
        cyc();
        stop          = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("stop_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("stop_mid_a", {18'd0, dac_dat_a}, 32'h1FFF);
        chk("stop_no_done", {31'd0, done}, 32'd0);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        cyc();

        // Trigger held high through reset must not fire
        trg_in = 1'b1;
        areset = 1'b1;
        cyc();
        cyc();
        areset = 1'b0;
        burst_len = 32'd4;
        cyc();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        cyc();
        cyc();
        chk("held_trg_no_play", {31'd0, s_axis_tready}, 32'd0);
        chk("held_trg_armed", {31'd0, busy}, 32'd1);
        trg_in = 1'b0;
        cyc();
        trg_in = 1'b1;
        cyc();
        chk("new_edge_play", {31'd0, s_axis_tready}, 32'd1);

        // Reset in the middle of that burst
        send(16'h0001, 16'h0001, 14'h1FFE, 14'h1FFE, 1'b0);
        send(16'h0002, 16'h0002, 14'h1FFD, 14'h1FFD, 1'b0);
        s_axis_tdata  = {16'h0003, 16'h0003};
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk("async_rst_a", {18'd0, dac_dat_a}, 32'h1FFF);
        chk("async_rst_b", {18'd0, dac_dat_b}, 32'h1FFF);
        chk("async_rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        cyc();
        s_axis_tvalid = 1'b0;
        cyc();
        areset = 1'b0;
        cyc();
        chk("post_rst_idle", {31'd0, s_axis_tready}, 32'd0);
        arm_and_trigger(32'd4);
        send(16'h0010, 16'hFFF0, 14'h1FEF, 14'h200F, 1'b0);
        send(16'h1000, 16'hF000, 14'h0FFF, 14'h2FFF, 1'b0);
        send(16'h8001, 16'h7FFE, 14'h3FFF, 14'h0000, 1'b0);
        send(16'h0000, 16'h0000, 14'h1FFF, 14'h1FFF, 1'b1);
        chk("fresh_done", {31'd0, done}, 32'd1);
        cyc();
        cyc();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
